// File: rtl/prim_esc_responder_if.sv
`default_nettype none
// ============================================================================
// Module : prim_esc_responder_if
// Brief  : Escalation differential pair, response pair and status flags
// Rev    : 1.0
// ============================================================================
interface prim_esc_responder_if;
  logic esc_p_i;
  logic esc_n_i;
  logic resp_p_o;
  logic resp_n_o;
  logic esc_req_o;
  logic sigint_o;
  logic timeout_o;

  modport master (
    output esc_p_i, esc_n_i,
    input  resp_p_o, resp_n_o, esc_req_o, sigint_o, timeout_o
  );

  modport slave (
    input  esc_p_i, esc_n_i,
    output resp_p_o, resp_n_o, esc_req_o, sigint_o, timeout_o
  );
endinterface
`default_nettype wire

// File: rtl/prim_esc_responder.sv
`default_nettype none
// ============================================================================
// Module : prim_esc_responder
// Brief  : Differential escalation receiver with ping response and timeout
// Rev    : 1.0
// ============================================================================
module prim_esc_responder #(
  parameter int unsigned TimeoutCycles = 1024,
  parameter int unsigned TimeoutCntW   = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  prim_esc_responder_if.slave bus
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CHECK  = 3'd1;
  localparam logic [2:0] ST_PING   = 3'd2;
  localparam logic [2:0] ST_ESC    = 3'd3;
  localparam logic [2:0] ST_SIGINT = 3'd4;

  localparam logic [TimeoutCntW-1:0] C_TIMEOUT = TimeoutCntW'(TimeoutCycles);
  localparam logic                   C_TO_EN   = (TimeoutCycles != 0);

  logic [2:0]             r_state;
  logic [2:0]             w_state_nxt;
  logic                   r_resp_p;
  logic                   r_resp_n;
  logic                   w_resp_p_nxt;
  logic                   w_resp_n_nxt;
  logic                   r_esc_req;
  logic                   r_timeout;
  logic                   w_timeout_nxt;
  logic [TimeoutCntW-1:0] r_cnt;
  logic [TimeoutCntW-1:0] w_cnt_nxt;
  logic                   w_hi;
  logic                   w_lo;
  logic                   w_ping_done;

  assign w_hi        = bus.esc_p_i & ~bus.esc_n_i;
  assign w_lo        = ~bus.esc_p_i & bus.esc_n_i;
  assign w_ping_done = (r_state == ST_PING);

  always_comb begin
    w_state_nxt  = r_state;
    w_resp_p_nxt = 1'b0;
    w_resp_n_nxt = 1'b1;
    case (r_state)
      ST_IDLE: begin
        if (w_hi) begin
          w_state_nxt  = ST_CHECK;
          w_resp_p_nxt = 1'b1;
          w_resp_n_nxt = 1'b0;
        end else if (!w_lo) begin
          w_state_nxt  = ST_SIGINT;
          w_resp_p_nxt = 1'b1;
          w_resp_n_nxt = 1'b1;
        end
      end
      ST_CHECK: begin
        if (w_hi) begin
          w_state_nxt = ST_ESC;
        end else if (w_lo) begin
          w_state_nxt = ST_PING;
        end else begin
          w_state_nxt  = ST_SIGINT;
          w_resp_p_nxt = 1'b1;
          w_resp_n_nxt = 1'b1;
        end
      end
      ST_PING: begin
        w_state_nxt  = ST_IDLE;
        w_resp_p_nxt = 1'b1;
        w_resp_n_nxt = 1'b0;
      end
      ST_ESC: begin
        if (w_hi) begin
          w_resp_p_nxt = ~r_resp_p;
          w_resp_n_nxt = r_resp_p;
        end else if (w_lo) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt  = ST_SIGINT;
          w_resp_p_nxt = 1'b1;
          w_resp_n_nxt = 1'b1;
        end
      end
      ST_SIGINT: begin
        // Both rails toggle together so the sender sees a protocol violation.
        if (w_lo) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_resp_p_nxt = ~r_resp_p;
          w_resp_n_nxt = ~r_resp_p;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // A completing ping in the same cycle the count saturates suppresses the timeout.
  always_comb begin
    w_cnt_nxt     = r_cnt;
    w_timeout_nxt = r_timeout;
    if (C_TO_EN) begin
      if (w_ping_done) begin
        w_cnt_nxt = '0;
      end else if (r_cnt != C_TIMEOUT) begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
      if (r_cnt == C_TIMEOUT && !w_ping_done) begin
        w_timeout_nxt = 1'b1;
      end
    end else begin
      w_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_resp_p  <= 1'b0;
      r_resp_n  <= 1'b1;
      r_esc_req <= 1'b0;
      r_timeout <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_resp_p  <= w_resp_p_nxt;
      r_resp_n  <= w_resp_n_nxt;
      r_esc_req <= (w_state_nxt == ST_ESC) | w_timeout_nxt;
      r_timeout <= w_timeout_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  assign bus.resp_p_o  = r_resp_p;
  assign bus.resp_n_o  = r_resp_n;
  assign bus.esc_req_o = r_esc_req;
  assign bus.sigint_o  = (r_state == ST_SIGINT);
  assign bus.timeout_o = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_prim_esc_responder.sv
`default_nettype none
// ============================================================================
// Module : tb_prim_esc_responder
// Brief  : Directed and random checks of prim_esc_responder against a model
// Rev    : 1.0
// ============================================================================
module tb_prim_esc_responder;

  localparam int unsigned T = 8;

  typedef enum int {M_IDLE, M_ARMED, M_PING, M_ESC, M_SIG} mode_t;

  logic clk = 1'b0;
  logic rst;
  int   n_chk;
  int   n_fail;

  mode_t       m_mode;
  logic        m_rp, m_rn, m_req, m_sig, m_to;
  int unsigned m_age;

  always #5 clk = ~clk;

  prim_esc_responder_if bus ();

  prim_esc_responder #(
    .TimeoutCycles(T),
    .TimeoutCntW  (16)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus.slave)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("resp_p",  bus.resp_p_o,  m_rp);
    chk("resp_n",  bus.resp_n_o,  m_rn);
    chk("esc_req", bus.esc_req_o, m_req);
    chk("sigint",  bus.sigint_o,  m_sig);
    chk("timeout", bus.timeout_o, m_to);
  endtask

  task automatic model_reset();
    m_mode = M_IDLE;
    m_rp   = 1'b0;
    m_rn   = 1'b1;
    m_req  = 1'b0;
    m_sig  = 1'b0;
    m_to   = 1'b0;
    m_age  = 0;
  endtask

  // Event-level reference: pair class decides the reaction, age counts cycles since the last ping.
  task automatic model_step(input logic p, input logic n);
    bit hi, lo, ping_now;
    hi       = p && !n;
    lo       = !p && n;
    ping_now = (m_mode == M_PING);
    if (T > 0 && m_age >= T && !ping_now) m_to = 1'b1;
    m_age = ping_now ? 0 : m_age + 1;
    if (m_mode == M_PING) begin
      m_mode = M_IDLE; m_rp = 1'b1; m_rn = 1'b0;
    end else if (!hi && !lo) begin
      if (m_mode == M_SIG) begin
        m_rp = !m_rp; m_rn = m_rp;
      end else begin
        m_mode = M_SIG; m_rp = 1'b1; m_rn = 1'b1;
      end
    end else if (lo) begin
      m_mode = (m_mode == M_ARMED) ? M_PING : M_IDLE;
      m_rp = 1'b0; m_rn = 1'b1;
    end else begin
      case (m_mode)
        M_IDLE:  begin m_mode = M_ARMED; m_rp = 1'b1; m_rn = 1'b0; end
        M_ARMED: begin m_mode = M_ESC;   m_rp = 1'b0; m_rn = 1'b1; end
        M_ESC:   begin m_rp = !m_rp; m_rn = !m_rp; end
        default: begin m_rp = !m_rp; m_rn = m_rp; end
      endcase
    end
    m_sig = (m_mode == M_SIG);
    m_req = (m_mode == M_ESC) || m_to;
  endtask

  // Entered and left at a falling edge.
  task automatic cycle(input logic p, input logic n);
    bus.esc_p_i = p;
    bus.esc_n_i = n;
    @(posedge clk);
    model_step(p, n);
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.esc_p_i = 1'b0;
    bus.esc_n_i = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_ping;
    logic [7:0] exp_esc_p, exp_esc_req;
    logic [4:0] exp_sig_p, exp_sig_n, exp_sig;
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    bus.esc_p_i = 1'b0;
    bus.esc_n_i = 1'b1;
    exp_ping    = 4'b1010;
    exp_esc_p   = 8'b1010_1000;
    exp_esc_req = 8'b0111_1100;
    exp_sig_p   = 5'b10100;
    exp_sig_n   = 5'b10101;
    exp_sig     = 5'b11110;
    @(negedge clk);

    do_reset();
    chk("reset_resp_p", bus.resp_p_o, 1'b0);
    chk("reset_resp_n", bus.resp_n_o, 1'b1);
    chk("reset_esc_req", bus.esc_req_o, 1'b0);

    for (int i = 0; i < 4; i++) begin
      cycle(i == 0, i != 0);
      chk("ping_resp_p", bus.resp_p_o, exp_ping[3-i]);
      chk("ping_esc_req", bus.esc_req_o, 1'b0);
    end

    do_reset();
    for (int i = 0; i < 8; i++) begin
      cycle(i < 6, i >= 6);
      chk("esc_resp_p", bus.resp_p_o, exp_esc_p[7-i]);
      chk("esc_req_seq", bus.esc_req_o, exp_esc_req[7-i]);
    end

    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i < 3)       cycle(1'b1, 1'b1);
      else if (i == 3) cycle(1'b1, 1'b0);
      else             cycle(1'b0, 1'b1);
      chk("sig_resp_p", bus.resp_p_o, exp_sig_p[4-i]);
      chk("sig_resp_n", bus.resp_n_o, exp_sig_n[4-i]);
      chk("sig_flag", bus.sigint_o, exp_sig[4-i]);
      chk("sig_esc_req", bus.esc_req_o, 1'b0);
    end

    do_reset();
    for (int i = 1; i <= 9; i++) begin
      cycle(1'b0, 1'b1);
      chk("to_flag", bus.timeout_o, i == 9);
      chk("to_esc_req", bus.esc_req_o, i == 9);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(i == 0, i != 0);
      chk("to_ping_resp_p", bus.resp_p_o, exp_ping[3-i]);
      chk("to_held", bus.timeout_o, 1'b1);
      chk("to_req_held", bus.esc_req_o, 1'b1);
    end

    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);
    chk("pre_rst_esc_req", bus.esc_req_o, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_resp_p", bus.resp_p_o, 1'b0);
    chk("mid_rst_resp_n", bus.resp_n_o, 1'b1);
    chk("mid_rst_esc_req", bus.esc_req_o, 1'b0);
    chk("mid_rst_sigint", bus.sigint_o, 1'b0);
    chk("mid_rst_timeout", bus.timeout_o, 1'b0);
    model_reset();
    bus.esc_p_i = 1'b0;
    bus.esc_n_i = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle(i == 0, i != 0);
      chk("post_rst_ping", bus.resp_p_o, exp_ping[3-i]);
    end

    do_reset();
    for (int i = 1; i <= 8; i++) cycle(i == 7, i != 7);
    for (int i = 9; i <= 18; i++) begin
      cycle(1'b0, 1'b1);
      chk("bound_timeout", bus.timeout_o, i == 18);
    end

    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int i = 0; i < 100; i++) begin
        int unsigned x;
        logic        b;
        x = $urandom_range(0, 9);
        b = 1'($urandom_range(0, 1));
        if (x < 3)      cycle(1'b1, 1'b0);
        else if (x < 9) cycle(1'b0, 1'b1);
        else            cycle(b, b);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
